// File: rtl/mem_miss_sequencer_pkg.sv
// Shared types and constants for the MEM-stage data cache miss sequencer.
// Holds the FSM state encoding and the cache/memory mux select values.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITEBACK = 3'd1,
        REFILL    = 3'd2,
        FILL      = 3'd3,
        COMPLETE  = 3'd4
    } seq_state_t;

    localparam logic SRC_MEMORY = 1'b0;
    localparam logic SRC_RT     = 1'b1;

    localparam logic ADDR_ALU = 1'b0;
    localparam logic ADDR_WB  = 1'b1;

    // The latency counter must reach MEM_LATENCY-1 without wrapping.
    function automatic logic latency_ok(input int latency, input int cnt_w);
        return (latency >= 1) && (latency <= 15) && ((1 << cnt_w) > latency);
    endfunction

endpackage

// File: rtl/mem_miss_sequencer_latency_counter.sv
// Memory latency counter: synchronous clear, count enable, and a flag
// raised while the count sits on the last cycle of a memory access.
module latency_counter #(
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LATENCY - 1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/mem_miss_sequencer.sv
// Data cache miss sequencer: turns MEM-stage load/store requests plus cache
// hit/dirty status into cache/memory strobes and pipeline stall controls.
module mem_miss_sequencer
    import mem_seq_pkg::*;
#(
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_load,
    input  logic             req_store,
    input  logic             req_is_word,
    input  logic             cache_hit,
    input  logic             cache_dirty,
    output logic             we_cache,
    output logic             cache_input_type,
    output logic             memory_address_type,
    output logic             we_memory,
    output logic             set_valid,
    output logic             set_dirty,
    output logic             is_word,
    output logic             register_write,
    output logic             pc_enable,
    output logic             lock,
    output logic [CNT_W-1:0] busy_cnt
);

    if (!latency_ok(MEM_LATENCY, CNT_W)) begin : g_bad_latency
        $error("mem_miss_sequencer: MEM_LATENCY must be 1..15 and fit in CNT_W bits");
    end

    seq_state_t state;
    logic       counting;
    logic       cnt_terminal;
    logic       any_req;

    assign any_req  = req_load | req_store;
    assign counting = (state == WRITEBACK) || (state == REFILL);

    latency_counter #(
        .MEM_LATENCY (MEM_LATENCY),
        .CNT_W       (CNT_W)
    ) u_latency_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (!counting || cnt_terminal),
        .enable   (counting),
        .count    (busy_cnt),
        .terminal (cnt_terminal)
    );

    // Cache status is only consulted in IDLE; once a miss is in flight the
    // sequence runs on the latency counter alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req && !cache_hit) begin
                        state <= cache_dirty ? WRITEBACK : REFILL;
                    end
                end
                WRITEBACK: begin
                    if (cnt_terminal) begin
                        state <= REFILL;
                    end
                end
                REFILL: begin
                    if (cnt_terminal) begin
                        state <= FILL;
                    end
                end
                FILL:     state <= COMPLETE;
                COMPLETE: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from state and the live request so that hits
    // finish in the same cycle and a miss stalls the pipe immediately.
    always_comb begin
        we_cache            = 1'b0;
        cache_input_type    = SRC_MEMORY;
        memory_address_type = ADDR_ALU;
        we_memory           = 1'b0;
        set_valid           = 1'b0;
        set_dirty           = 1'b0;
        is_word             = 1'b0;
        register_write      = 1'b0;
        pc_enable           = 1'b1;
        lock                = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (any_req && !cache_hit) begin
                        lock      = 1'b1;
                        pc_enable = 1'b0;
                    end else if (req_store) begin
                        we_cache         = 1'b1;
                        cache_input_type = SRC_RT;
                        set_valid        = 1'b1;
                        set_dirty        = 1'b1;
                        is_word          = req_is_word;
                    end else if (req_load) begin
                        register_write = 1'b1;
                    end
                end
                WRITEBACK: begin
                    we_memory           = 1'b1;
                    memory_address_type = ADDR_WB;
                    lock                = 1'b1;
                    pc_enable           = 1'b0;
                end
                REFILL: begin
                    memory_address_type = ADDR_ALU;
                    lock                = 1'b1;
                    pc_enable           = 1'b0;
                end
                FILL: begin
                    we_cache         = 1'b1;
                    cache_input_type = SRC_MEMORY;
                    is_word          = 1'b1;
                    set_valid        = 1'b1;
                    set_dirty        = 1'b0;
                    lock             = 1'b1;
                    pc_enable        = 1'b0;
                end
                COMPLETE: begin
                    if (req_store) begin
                        we_cache         = 1'b1;
                        cache_input_type = SRC_RT;
                        set_valid        = 1'b1;
                        set_dirty        = 1'b1;
                        is_word          = req_is_word;
                    end else if (req_load) begin
                        register_write = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_miss_sequencer.sv
// Scoreboard bench for mem_miss_sequencer: each driven cycle queues its
// expected output vector, and a negedge monitor pops and compares it.
module tb_mem_miss_sequencer;

    localparam int MEM_LATENCY = 4;
    localparam int CNT_W       = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset       = 1'b1;
    logic req_load    = 1'b0;
    logic req_store   = 1'b0;
    logic req_is_word = 1'b0;
    logic cache_hit   = 1'b0;
    logic cache_dirty = 1'b0;

    logic             we_cache;
    logic             cache_input_type;
    logic             memory_address_type;
    logic             we_memory;
    logic             set_valid;
    logic             set_dirty;
    logic             is_word;
    logic             register_write;
    logic             pc_enable;
    logic             lock;
    logic [CNT_W-1:0] busy_cnt;

    mem_miss_sequencer #(
        .MEM_LATENCY (MEM_LATENCY),
        .CNT_W       (CNT_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_load            (req_load),
        .req_store           (req_store),
        .req_is_word         (req_is_word),
        .cache_hit           (cache_hit),
        .cache_dirty         (cache_dirty),
        .we_cache            (we_cache),
        .cache_input_type    (cache_input_type),
        .memory_address_type (memory_address_type),
        .we_memory           (we_memory),
        .set_valid           (set_valid),
        .set_dirty           (set_dirty),
        .is_word             (is_word),
        .register_write      (register_write),
        .pc_enable           (pc_enable),
        .lock                (lock),
        .busy_cnt            (busy_cnt)
    );

    // Vector layout: we_cache, cache_input_type, memory_address_type, we_memory,
    // set_valid, set_dirty, is_word, register_write, pc_enable, lock, busy_cnt.
    logic [13:0] actual_vec;
    assign actual_vec = {we_cache, cache_input_type, memory_address_type, we_memory,
                         set_valid, set_dirty, is_word, register_write, pc_enable,
                         lock, busy_cnt};

    int checks   = 0;
    int failures = 0;

    logic [13:0] exp_q[$];
    string       name_q[$];

    function automatic logic [13:0] mk(input logic wc, input logic cit, input logic mat,
                                       input logic wem, input logic sv, input logic sd,
                                       input logic iw, input logic rw, input logic pce,
                                       input logic lk, input logic [3:0] cnt);
        return {wc, cit, mat, wem, sv, sd, iw, rw, pce, lk, cnt};
    endfunction

    logic [13:0] idle_v;
    logic [13:0] miss_detect_v;
    assign idle_v        = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
    assign miss_detect_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0);

    task automatic applyStimulus(input string nm, input logic rst, input logic ld,
                                 input logic st, input logic w, input logic hit,
                                 input logic dirty, input logic chk,
                                 input logic [13:0] expv);
        @(posedge clk);
        #1;
        reset       = rst;
        req_load    = ld;
        req_store   = st;
        req_is_word = w;
        cache_hit   = hit;
        cache_dirty = dirty;
        if (chk) begin
            exp_q.push_back(expv);
            name_q.push_back(nm);
        end
    endtask

    task automatic checkOutput(input string nm, input logic [13:0] expv);
        checks++;
        if (actual_vec !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", nm, actual_vec, expv);
        end
    endtask

    logic [2:0] prev_req   = 3'b000;
    logic       prev_lock  = 1'b0;
    logic       prev_reset = 1'b1;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(name_q.pop_front(), exp_q.pop_front());
        end
        if (prev_lock && !reset && !prev_reset) begin
            checks++;
            if ({req_load, req_store, req_is_word} !== prev_req) begin
                failures++;
                $display("[TB] FAIL req_stable: got %b, expected %b",
                         {req_load, req_store, req_is_word}, prev_req);
            end
        end
        prev_req   = {req_load, req_store, req_is_word};
        prev_lock  = lock;
        prev_reset = reset;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            applyStimulus("reset", 1, 1, 0, 1, 0, 0, 1, idle_v);
        end
        applyStimulus("idle", 0, 0, 0, 0, 0, 0, 1, idle_v);

        applyStimulus("load_hit", 0, 1, 0, 1, 1, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'd0));
        applyStimulus("store_hit_word", 0, 0, 1, 1, 1, 0, 1, mk(1, 1, 0, 0, 1, 1, 1, 0, 1, 0, 4'd0));
        applyStimulus("store_hit_byte", 0, 0, 1, 0, 1, 1, 1, mk(1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 4'd0));
        applyStimulus("both_req_hit", 0, 1, 1, 1, 1, 0, 1, mk(1, 1, 0, 0, 1, 1, 1, 0, 1, 0, 4'd0));
        applyStimulus("idle", 0, 0, 0, 0, 0, 0, 1, idle_v);

        // Clean load miss; cache status wiggles mid-miss and must be ignored.
        applyStimulus("clean_detect", 0, 1, 0, 1, 0, 0, 1, miss_detect_v);
        for (int i = 0; i < MEM_LATENCY; i++) begin
            applyStimulus("clean_refill", 0, 1, 0, 1, logic'(i == 2), 1, 1,
                          mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'(i)));
        end
        applyStimulus("clean_fill", 0, 1, 0, 1, 0, 0, 1, mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 4'd0));
        applyStimulus("clean_complete", 0, 1, 0, 1, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'd0));
        applyStimulus("idle", 0, 0, 0, 0, 0, 0, 1, idle_v);

        // Dirty byte store miss: write-back, refill, fill, then the store lands.
        applyStimulus("dirty_detect", 0, 0, 1, 0, 0, 1, 1, miss_detect_v);
        for (int i = 0; i < MEM_LATENCY; i++) begin
            applyStimulus("dirty_writeback", 0, 0, 1, 0, logic'(i == 1), 0, 1,
                          mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 4'(i)));
        end
        for (int i = 0; i < MEM_LATENCY; i++) begin
            applyStimulus("dirty_refill", 0, 0, 1, 0, 0, 1, 1,
                          mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'(i)));
        end
        applyStimulus("dirty_fill", 0, 0, 1, 0, 0, 1, 1, mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 4'd0));
        applyStimulus("dirty_complete", 0, 0, 1, 0, 0, 1, 1, mk(1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 4'd0));
        applyStimulus("idle", 0, 0, 0, 0, 0, 0, 1, idle_v);

        // Reset lands on the second write-back cycle and must abort cleanly.
        applyStimulus("abort_detect", 0, 1, 0, 1, 0, 1, 1, miss_detect_v);
        applyStimulus("abort_writeback", 0, 1, 0, 1, 0, 1, 1, mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 4'd0));
        applyStimulus("abort_reset", 1, 0, 0, 0, 0, 0, 0, idle_v);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("abort_idle", 0, 0, 0, 0, 0, 0, 1, idle_v);
        end
        applyStimulus("post_abort_load_hit", 0, 1, 0, 0, 1, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'd0));
        applyStimulus("idle", 0, 0, 0, 0, 0, 0, 1, idle_v);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
